// File: rtl/seg7_pkg.sv
// Shared definitions for the multi-digit 7-segment driver: segment codes,
// FSM state type and the BCD width helper.
package seg7_pkg;

  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_A     = 7'h08;
  localparam logic [6:0] SEG_B     = 7'h03;
  localparam logic [6:0] SEG_C     = 7'h46;
  localparam logic [6:0] SEG_D     = 7'h21;
  localparam logic [6:0] SEG_E     = 7'h06;
  localparam logic [6:0] SEG_F     = 7'h0E;
  localparam logic [6:0] SEG_DASH  = 7'h3F;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    LOAD  = 2'd2
  } seg7_state_t;

  // ceil(data_w * log10(2)) + 1, in integer arithmetic
  function automatic int unsigned bcd_digits(input int unsigned data_w);
    return (data_w * 30103 + 99999) / 100000 + 1;
  endfunction

endpackage

// File: rtl/seg7_digit_enc.sv
// Combinational nibble-to-segment encoder, active-low, bit order g..a.
// Dash takes priority over blank, blank over the nibble value.
module seg7_digit_enc
  import seg7_pkg::*;
(
  input  logic [3:0] nibble,
  input  logic       blank,
  input  logic       dash,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    if (dash) begin
      seg = SEG_DASH;
    end else if (!blank) begin
      unique case (nibble)
        4'h0: seg = SEG_0;
        4'h1: seg = SEG_1;
        4'h2: seg = SEG_2;
        4'h3: seg = SEG_3;
        4'h4: seg = SEG_4;
        4'h5: seg = SEG_5;
        4'h6: seg = SEG_6;
        4'h7: seg = SEG_7;
        4'h8: seg = SEG_8;
        4'h9: seg = SEG_9;
        4'hA: seg = SEG_A;
        4'hB: seg = SEG_B;
        4'hC: seg = SEG_C;
        4'hD: seg = SEG_D;
        4'hE: seg = SEG_E;
        4'hF: seg = SEG_F;
        default: seg = SEG_BLANK;
      endcase
    end
  end

endmodule

// File: rtl/seg7_multi_display.sv
// Multi-digit 7-segment driver: decimal (sequential double-dabble) or hex
// display with leading-zero blanking and overflow dashes.
// Optional blink overlay enabled by defining SEG7_BLINK_EN.
module seg7_multi_display
  import seg7_pkg::*;
#(
  parameter int unsigned NUM_DIGITS = 6,
  parameter int unsigned DATA_W     = 20
`ifdef SEG7_BLINK_EN
  , parameter int unsigned BLINK_DIV = 25_000_000
`endif
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [DATA_W-1:0]       data_in,
  input  logic                    mode,
  input  logic                    blank_lz,
`ifdef SEG7_BLINK_EN
  input  logic                    blink,
`endif
  output logic                    busy,
  output logic                    done,
  output logic                    ovf,
  output logic [7*NUM_DIGITS-1:0] hex_seg
);

  localparam int unsigned BCD_W  = bcd_digits(DATA_W);
  localparam int unsigned CNT_W  = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam int unsigned W_A    = (4 * NUM_DIGITS > DATA_W) ? 4 * NUM_DIGITS : DATA_W;
  localparam int unsigned PAD_W  = (W_A > 4 * BCD_W) ? W_A : 4 * BCD_W;

  seg7_state_t              state;
  logic [DATA_W-1:0]        bin_reg;
  logic [4*BCD_W-1:0]       bcd_reg;
  logic [4*BCD_W-1:0]       bcd_adj;
  logic [4*BCD_W-1:0]       bcd_next;
  logic [CNT_W-1:0]         cnt;
  logic                     mode_r;
  logic                     blank_r;
  logic [7*NUM_DIGITS-1:0]  seg_reg;
  logic [7*NUM_DIGITS-1:0]  enc_seg;
  logic                     ovf_r;
  logic                     done_r;
  logic [PAD_W-1:0]         src;
  logic                     ovf_calc;
  logic [NUM_DIGITS-1:0]    dig_blank;

  // Double-dabble step: add 3 to digits >= 5, then shift in the next binary MSB
  always_comb begin
    bcd_adj = bcd_reg;
    for (int unsigned k = 0; k < BCD_W; k++) begin
      if (bcd_reg[4*k +: 4] >= 4'd5)
        bcd_adj[4*k +: 4] = bcd_reg[4*k +: 4] + 4'd3;
    end
    bcd_next = (bcd_adj << 1) | {{(4*BCD_W-1){1'b0}}, bin_reg[DATA_W-1]};
  end

  // Both modes reduce to a nibble vector: digits below NUM_DIGITS are shown,
  // anything nonzero above them is overflow.
  always_comb begin
    src = '0;
    if (mode_r)
      src[DATA_W-1:0] = bin_reg;
    else
      src[4*BCD_W-1:0] = bcd_reg;
    ovf_calc = |(src >> (4 * NUM_DIGITS));
    dig_blank = '0;
    for (int unsigned i = 1; i < NUM_DIGITS; i++)
      dig_blank[i] = blank_r && !ovf_calc && !(|(src >> (4 * i)));
  end

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_enc
    seg7_digit_enc u_enc (
      .nibble (src[4*g +: 4]),
      .blank  (dig_blank[g]),
      .dash   (ovf_calc),
      .seg    (enc_seg[7*g +: 7])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      bin_reg <= '0;
      bcd_reg <= '0;
      cnt     <= '0;
      mode_r  <= 1'b0;
      blank_r <= 1'b0;
      seg_reg <= '1;
      ovf_r   <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            bin_reg <= data_in;
            mode_r  <= mode;
            blank_r <= blank_lz;
            bcd_reg <= '0;
            cnt     <= CNT_W'(DATA_W - 1);
            state   <= mode ? LOAD : SHIFT;
          end
        end
        SHIFT: begin
          bcd_reg <= bcd_next;
          bin_reg <= bin_reg << 1;
          if (cnt == '0)
            state <= LOAD;
          else
            cnt <= cnt - 1'b1;
        end
        LOAD: begin
          seg_reg <= enc_seg;
          ovf_r   <= ovf_calc;
          done_r  <= 1'b1;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy = (state != IDLE);
  assign done = done_r;
  assign ovf  = ovf_r;

`ifdef SEG7_BLINK_EN
  logic [31:0] blink_cnt;
  logic        phase;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blink_cnt <= '0;
      phase     <= 1'b0;
    end else if (blink_cnt == 32'(BLINK_DIV - 1)) begin
      blink_cnt <= '0;
      phase     <= ~phase;
    end else begin
      blink_cnt <= blink_cnt + 32'd1;
    end
  end

  assign hex_seg = seg_reg | {(7*NUM_DIGITS){blink & phase}};
`else
  assign hex_seg = seg_reg;
`endif

endmodule

// File: tb/tb_seg7_multi_display.sv
// Self-checking bench for seg7_multi_display (default build, default params):
// directed cases plus randomized conversions against an arithmetic model.
module tb_seg7_multi_display;

  localparam int unsigned ND = 6;
  localparam int unsigned DW = 20;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            start;
  logic [DW-1:0]   data_in;
  logic            mode;
  logic            blank_lz;
  logic            busy;
  logic            done;
  logic            ovf;
  logic [7*ND-1:0] hex_seg;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  logic [6:0] seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  seg7_multi_display #(.NUM_DIGITS(ND), .DATA_W(DW)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .data_in  (data_in),
    .mode     (mode),
    .blank_lz (blank_lz),
    .busy     (busy),
    .done     (done),
    .ovf      (ovf),
    .hex_seg  (hex_seg)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Expected display image from plain positional arithmetic
  function automatic logic [7*ND-1:0] model_img(input int unsigned v, input bit m,
                                                input bit blz, output bit ov);
    int unsigned base;
    int unsigned x;
    int unsigned top;
    int unsigned dig [ND];
    logic [7*ND-1:0] img;
    base = m ? 16 : 10;
    x = v;
    for (int i = 0; i < ND; i++) begin
      dig[i] = x % base;
      x = x / base;
    end
    ov = (x != 0);
    top = 0;
    for (int i = 0; i < ND; i++)
      if (dig[i] != 0) top = i;
    for (int i = 0; i < ND; i++) begin
      if (ov)
        img[7*i +: 7] = 7'h3F;
      else if (blz && i > top)
        img[7*i +: 7] = 7'h7F;
      else
        img[7*i +: 7] = seg_tab[dig[i]];
    end
    return img;
  endfunction

  // Caller is at a negedge; start is presented immediately (possibly in a done cycle)
  task automatic run_conv(input int unsigned v, input bit m, input bit blz, input bit inj);
    logic [7*ND-1:0] exp_img;
    logic [7*ND-1:0] prev;
    bit              exp_ov;
    bit              held;
    int unsigned     cyc;
    int unsigned     busy_cyc;
    exp_img  = model_img(v, m, blz, exp_ov);
    prev     = hex_seg;
    data_in  = DW'(v);
    mode     = m;
    blank_lz = blz;
    start    = 1'b1;
    @(negedge clk);
    start    = 1'b0;
    data_in  = DW'($urandom);
    mode     = 1'($urandom);
    blank_lz = 1'($urandom);
    cyc = 1;
    busy_cyc = 0;
    held = 1'b1;
    while (!done && cyc < 100) begin
      if (busy) busy_cyc++;
      if (hex_seg !== prev) held = 1'b0;
      if (inj && cyc == 4) begin
        start   = 1'b1;
        data_in = DW'($urandom);
      end
      if (inj && cyc == 5) start = 1'b0;
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    chk("latency", 64'(cyc), m ? 64'd2 : 64'(DW + 2));
    chk("busy_cycles", 64'(busy_cyc), m ? 64'd1 : 64'(DW + 1));
    chk("seg_held", 64'(held), 64'd1);
    chk("done_busy", 64'(busy), 64'd0);
    chk("hex_seg", 64'(hex_seg), 64'(exp_img));
    chk("ovf", 64'(ovf), 64'(exp_ov));
  endtask

  initial begin
    int unsigned done_cnt;
    int unsigned v;
    rst_n    = 1'b0;
    start    = 1'b0;
    data_in  = '0;
    mode     = 1'b0;
    blank_lz = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_seg", 64'(hex_seg), 64'h3FF_FFFF_FFFF);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_ovf", 64'(ovf), 64'd0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("idle_seg", 64'(hex_seg), 64'h3FF_FFFF_FFFF);
    chk("idle_busy", 64'(busy), 64'd0);

    run_conv(123456, 1'b0, 1'b0, 1'b0);
    run_conv(42, 1'b0, 1'b1, 1'b0);
    run_conv(0, 1'b0, 1'b1, 1'b0);
    run_conv(1_000_000, 1'b0, 1'b0, 1'b0);
    run_conv(999_999, 1'b0, 1'b1, 1'b0);
    run_conv(20'hABCDE, 1'b1, 1'b1, 1'b0);
    @(negedge clk);
    chk("done_pulse", 64'(done), 64'd0);
    run_conv(654_321, 1'b0, 1'b0, 1'b1);
    run_conv(0, 1'b1, 1'b0, 1'b0);

    for (int i = 0; i < 40; i++) begin
      v = ($urandom_range(0, 2) == 0) ? $urandom_range(0, 999) : ($urandom & 32'hFFFFF);
      run_conv(v, 1'($urandom), 1'($urandom), 1'($urandom_range(0, 3) == 0));
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    // Reset during SHIFT after an overflow image is on display
    run_conv(1_048_575, 1'b0, 1'b0, 1'b0);
    data_in = DW'(123);
    mode    = 1'b0;
    start   = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (6) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_seg", 64'(hex_seg), 64'h3FF_FFFF_FFFF);
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_ovf", 64'(ovf), 64'd0);
    done_cnt = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (30) begin
      @(negedge clk);
      if (done) done_cnt++;
    end
    chk("midrst_nodone", 64'(done_cnt), 64'd0);
    chk("midrst_seg_after", 64'(hex_seg), 64'h3FF_FFFF_FFFF);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
